instruction_fetch_unit: RTL and testbench

Consumer side of the program counter in the RISC-V instruction decoder path. Issues instruction-memory reads at the current PC and pulses the counter's enable once per issued read. Buffers returned words with their addresses in a 2-entry queue for the decoder. Flushes itself on a branch/jump redirect.

---
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues instruction-memory reads at the current PC, advances the
// program counter once per issued read, and buffers returned words in a 2-entry queue.
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_enable,
  input  logic        redirect,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_word_q [2];

  logic        pop;
  logic        push;
  logic        issue;
  logic        wr_idx;
  logic [1:0]  count_after;

  // Queue plus in-flight read never exceeds two, so a push always finds a free slot.
  always_comb begin
    pop         = (count_q != 2'd0) & inst_ready;
    push        = (state_q == S_WAIT) & mem_ack & ~redirect;
    count_after = count_q + {1'b0, push} - {1'b0, pop};
    issue       = ~rst & ~redirect & (count_after < 2'd2) &
                  ((state_q == S_IDLE) | ((state_q == S_WAIT) & mem_ack));
    // Tail slot: head when empty or when a full queue is popping, the other slot otherwise.
    wr_idx      = head_q ^ count_q[0];
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    count_d    = count_after;
    head_d     = head_q ^ pop;

    if (redirect) begin
      count_d = 2'd0;
      head_d  = head_q;
    end

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d    = S_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_in;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          if (mem_ack) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d   = S_DROP;
          end
        end else if (issue) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_in;
        end else if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      S_DROP: begin
        // The discarded read must still complete before a new one may start.
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  // NOTE: the two queue slots are reset because inst/inst_pc must read zero out of reset; larger storage would normally stay unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]   <= 32'd0;
        q_word_q[i] <= 32'd0;
      end
    end else if (push) begin
      q_pc_q[wr_idx]   <= mem_addr_q;
      q_word_q[wr_idx] <= mem_rdata;
    end
  end

  assign pc_enable  = issue;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst       = q_word_q[head_q];
  assign inst_pc    = q_pc_q[head_q];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a transaction-level model (expected-instruction queue,
// one in-flight read, PC counter, variable-latency memory) checked every cycle.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic        redirect;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_enable  (pc_enable),
    .redirect   (redirect),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      exp_q[$];
  bit          infl;
  bit          dropping;
  logic [31:0] infl_addr;
  logic [31:0] tb_pc;
  int          wait_cnt;
  int          cur_l;
  int          lat_min;
  int          lat_max;
  int          stray_pct;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    infl      = 1'b0;
    dropping  = 1'b0;
    infl_addr = 32'd0;
    tb_pc     = 32'd0;
    wait_cnt  = 0;
    cur_l     = lat_min;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, ".pc_enable"},  32'(pc_enable),  32'd0);
    check({pfx, ".mem_req"},    32'(mem_req),    32'd0);
    check({pfx, ".mem_addr"},   mem_addr,        32'd0);
    check({pfx, ".inst_valid"}, 32'(inst_valid), 32'd0);
    check({pfx, ".inst"},       inst,            32'd0);
    check({pfx, ".inst_pc"},    inst_pc,         32'd0);
  endtask

  task automatic check_outputs();
    check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("inst_pc", inst_pc, exp_q[0].pc);
      check("inst",    inst,    exp_q[0].word);
    end
    check("mem_req", 32'(mem_req), 32'(infl));
    if (infl) check("mem_addr", mem_addr, infl_addr);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rdy, input bit rdr, input logic [31:0] tgt);
    bit   ack;
    bit   ack_eff;
    bit   pop_m;
    bit   exp_issue;
    bit   sampled_req;
    int   size_after;
    pc_in       = tb_pc;
    inst_ready  = rdy;
    redirect    = rdr;
    sampled_req = mem_req;
    if (sampled_req) ack = (wait_cnt + 1 >= cur_l);
    else             ack = ($urandom_range(99) < stray_pct);
    mem_ack   = ack;
    mem_rdata = (ack && sampled_req) ? word_of(mem_addr) : $urandom();

    pop_m      = (exp_q.size() != 0) && rdy;
    ack_eff    = infl && ack;
    size_after = exp_q.size() + ((ack_eff && !dropping) ? 1 : 0) - (pop_m ? 1 : 0);
    exp_issue  = !rdr && (size_after < 2) && (!infl || (ack_eff && !dropping));
    #1;
    check("pc_enable", 32'(pc_enable), 32'(exp_issue));

    @(posedge clk);
    if (rdr) begin
      exp_q.delete();
      if (ack_eff) begin
        infl     = 1'b0;
        dropping = 1'b0;
      end else if (infl) begin
        dropping = 1'b1;
      end
      tb_pc = tgt;
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (ack_eff && !dropping) exp_q.push_back(entry_t'{pc: infl_addr, word: word_of(infl_addr)});
      if (ack_eff) begin
        infl     = 1'b0;
        dropping = 1'b0;
      end
      if (exp_issue) begin
        infl      = 1'b1;
        infl_addr = tb_pc;
        tb_pc     = tb_pc + 32'd4;
      end
    end
    if (sampled_req) begin
      if (ack) begin
        wait_cnt = 0;
        cur_l    = $urandom_range(lat_max, lat_min);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end

    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_latency(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    cur_l   = lo;
  endtask

  task automatic random_run(input int n);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = $urandom() & 32'hFFFF_FFFC;
      step($urandom_range(3) != 0, $urandom_range(15) == 0, tgt);
    end
  endtask

  initial begin
    bit found;
    rst        = 1'b1;
    pc_in      = 32'd0;
    redirect   = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    inst_ready = 1'b0;
    stray_pct  = 0;
    set_latency(1, 1);
    model_reset();

    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
    end
    rst = 1'b0;

    // Startup and L=1 streaming: PCs 0,4,8,... on consecutive cycles.
    repeat (8) step(1'b1, 1'b0, 32'd0);

    // Backpressure: queue fills to two and fetching stalls; one pop frees one slot.
    repeat (6) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 32'd0);

    // Fixed latency of three cycles.
    set_latency(3, 3);
    repeat (14) step(1'b1, 1'b0, 32'd0);

    // Redirect while a read is outstanding and one entry is queued.
    set_latency(4, 4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_q.size() == 1 && infl && !dropping && (wait_cnt + 1 < cur_l)) found = 1'b1;
      else step(exp_q.size() == 2, 1'b0, 32'd0);
    end
    check("redirect_setup", 32'(found), 32'd1);
    step(1'b0, 1'b1, 32'h0000_0100);
    check("redirect.inst_valid", 32'(inst_valid), 32'd0);
    check("redirect.mem_req_held", 32'(mem_req), 32'd1);
    for (int i = 0; i < 30 && !inst_valid; i++) step(1'b1, 1'b0, 32'd0);
    check("redirect.first_valid", 32'(inst_valid), 32'd1);
    check("redirect.first_pc", inst_pc, 32'h0000_0100);

    // Redirect coincident with an ack and a pop.
    set_latency(1, 1);
    repeat (5) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0200);
    check("coincident.empty", 32'(inst_valid), 32'd0);
    repeat (4) step(1'b1, 1'b0, 32'd0);

    // Randomized traffic with mixed latencies, stray acks and redirects.
    set_latency(1, 4);
    stray_pct = 10;
    random_run(1500);

    // Asynchronous reset in the middle of a cycle, with a late ack during reset.
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("async_reset_hold");
    rst = 1'b0;
    model_reset();
    stray_pct = 100;
    step(1'b1, 1'b0, 32'd0);
    stray_pct = 10;
    random_run(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
